// File: rtl/sensor_mon_pkg.sv
// Shared encodings for the sensor scan monitor: FSM states, reader enable codes
// and channel indices.
package sensor_mon_pkg;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_START   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_CAPTURE = 2'd3;

    localparam logic [2:0] EN_NONE = 3'b000;
    localparam logic [2:0] EN_CH0  = 3'b001;
    localparam logic [2:0] EN_CH1  = 3'b010;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    function automatic logic [2:0] ch_en_code(input logic ch);
        return (ch == CH1) ? EN_CH1 : EN_CH0;
    endfunction

endpackage

// File: rtl/sensor_avg_acc.sv
// Per-channel sample accumulator: sums 2^AVG_LOG2 samples, publishes the truncated
// mean, and (with SENSOR_ALARM_EN defined) tracks a hysteretic threshold alarm.
module sensor_avg_acc
    import sensor_mon_pkg::*;
#(
    parameter int AVG_LOG2 = 3
`ifdef SENSOR_ALARM_EN
    ,
    parameter logic [11:0] HI_TH  = 12'd3000,
    parameter logic [11:0] CLR_TH = 12'd2936
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        add_i,
    input  logic [11:0] sample_i,
    output logic [11:0] avg_o,
    output logic        valid_o,
    output logic        alarm_o
);

    localparam int SW = 12 + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

    logic [SW-1:0] sum_q, sum_d, sum_next;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [11:0]   avg_q, avg_d;
    logic          valid_q, valid_d;
    logic          wrap;

    always_comb begin
        sum_next = sum_q + SW'(sample_i);
        wrap     = add_i && (cnt_q == CNT_LAST);
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        avg_d    = avg_q;
        valid_d  = 1'b0;
        if (wrap) begin
            avg_d   = 12'(sum_next >> AVG_LOG2);
            valid_d = 1'b1;
            sum_d   = '0;
            cnt_d   = '0;
        end else if (add_i) begin
            sum_d = sum_next;
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q   <= '0;
            cnt_q   <= '0;
            avg_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            avg_q   <= avg_d;
            valid_q <= valid_d;
        end
    end

    assign avg_o   = avg_q;
    assign valid_o = valid_q;

`ifdef SENSOR_ALARM_EN
    logic alarm_q, alarm_d;

    // Between CLR_TH and HI_TH the alarm keeps its previous level.
    always_comb begin
        alarm_d = alarm_q;
        if (wrap) begin
            if (avg_d >= HI_TH) begin
                alarm_d = 1'b1;
            end else if (avg_d < CLR_TH) begin
                alarm_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm_o = alarm_q;
`else
    assign alarm_o = 1'b0;
`endif

endmodule

// File: rtl/sensor_scan_monitor.sv
// Drives the AD7928 SPI reader alternating ch0/ch1 and averages the returned samples.
// Optional SENSOR_ALARM_EN builds per-channel threshold alarms with hysteresis.
//
// state     | meaning
// S_IDLE    | no frame in flight, waiting for run
// S_START   | issue one-cycle enable code for req_ch
// S_WAIT    | reader frame in progress, frame timer counting down
// S_CAPTURE | take sample_12b, credit it to prev_ch (result lags one frame)
module sensor_scan_monitor
    import sensor_mon_pkg::*;
#(
    parameter int          FRAME_CYCLES = 400,
    parameter int          AVG_LOG2     = 3,
    parameter logic [11:0] HI_CH0       = 12'd3000,
    parameter logic [11:0] HI_CH1       = 12'd3500,
    parameter logic [11:0] HYST         = 12'd64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic [11:0] sample_12b,
    output logic [2:0]  enable,
    output logic [11:0] avg_ch0,
    output logic [11:0] avg_ch1,
    output logic        avg_valid,
    output logic        avg_ch,
    output logic [1:0]  alarm,
    output logic        busy
);

    localparam int TW = $clog2(FRAME_CYCLES + 1);
    localparam logic [TW-1:0] WAIT_LOAD = TW'(FRAME_CYCLES - 1);

    if (HYST >= HI_CH0 || HYST >= HI_CH1) begin : g_bad_hyst
        $error("sensor_scan_monitor: HYST must be below HI_CH0 and HI_CH1");
    end

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [2:0]    enable_q, enable_d;
    logic          req_ch_q, req_ch_d;
    logic          prev_ch_q, prev_ch_d;
    logic          primed_q, primed_d;
    logic          add_ch0, add_ch1;
    logic          valid_ch0, valid_ch1;
    logic          alarm_ch0, alarm_ch1;

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        enable_d  = EN_NONE;
        req_ch_d  = req_ch_q;
        prev_ch_d = prev_ch_q;
        primed_d  = primed_q;
        add_ch0   = 1'b0;
        add_ch1   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                enable_d = ch_en_code(req_ch_q);
                tmr_d    = WAIT_LOAD;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (tmr_q == '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_CAPTURE: begin
                // The first frame after start returns a stale conversion.
                if (!primed_q) begin
                    primed_d = 1'b1;
                end else begin
                    add_ch0 = (prev_ch_q == CH0);
                    add_ch1 = (prev_ch_q == CH1);
                end
                prev_ch_d = req_ch_q;
                req_ch_d  = ~req_ch_q;
                if (run) begin
                    state_d = S_START;
                end else begin
                    state_d  = S_IDLE;
                    primed_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            enable_q  <= EN_NONE;
            req_ch_q  <= CH0;
            prev_ch_q <= CH0;
            primed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            enable_q  <= enable_d;
            req_ch_q  <= req_ch_d;
            prev_ch_q <= prev_ch_d;
            primed_q  <= primed_d;
        end
    end

    sensor_avg_acc #(
        .AVG_LOG2(AVG_LOG2)
`ifdef SENSOR_ALARM_EN
        ,
        .HI_TH   (HI_CH0),
        .CLR_TH  (HI_CH0 - HYST)
`endif
    ) u_acc_ch0 (
        .clk     (clk),
        .reset_n (reset_n),
        .add_i   (add_ch0),
        .sample_i(sample_12b),
        .avg_o   (avg_ch0),
        .valid_o (valid_ch0),
        .alarm_o (alarm_ch0)
    );

    sensor_avg_acc #(
        .AVG_LOG2(AVG_LOG2)
`ifdef SENSOR_ALARM_EN
        ,
        .HI_TH   (HI_CH1),
        .CLR_TH  (HI_CH1 - HYST)
`endif
    ) u_acc_ch1 (
        .clk     (clk),
        .reset_n (reset_n),
        .add_i   (add_ch1),
        .sample_i(sample_12b),
        .avg_o   (avg_ch1),
        .valid_o (valid_ch1),
        .alarm_o (alarm_ch1)
    );

    assign enable    = enable_q;
    assign avg_valid = valid_ch0 | valid_ch1;
    assign avg_ch    = valid_ch1;
    assign alarm     = {alarm_ch1, alarm_ch0};
    assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/sensor_scan_monitor.md
# sensor_scan_monitor

Schedules AD7928 conversions by driving the SPI reader's 3-bit `enable` code, alternating channel 0 (temperature) and channel 1 (light). Captures the reader's `sample_12b` after each frame and attributes it to the correct channel, accounting for the ADC's one-frame result pipeline. Averages 2^AVG_LOG2 samples per channel and raises per-channel threshold alarms with hysteresis. Sits directly around the SPI reader: it drives its `enable` input and consumes its `sample_12b` output.

## Interface
- `FRAME_CYCLES`, 400: clk cycles per reader frame (IDLE + 17 SCLK periods + GAP); must be ≥ 360 at 50 MHz/2.5 MHz.
- `AVG_LOG2`, 3: log2 of samples averaged per channel (0..6).
- `HI_CH0`, 12'd3000: channel-0 alarm set threshold.
- `HI_CH1`, 12'd3500: channel-1 alarm set threshold.
- `HYST`, 12'd64: alarm clear hysteresis, with HYST < HI_CHx.
- `clk`  in  1  system clock, 50 MHz.
- `reset_n`  in  1  asynchronous active-low reset.
- `run`  in  1  level; 1 = scan continuously.
- `sample_12b`  in  12  latest result from the SPI reader.
- `enable`  out  3  to the SPI reader: 3'b001 = request ch0, 3'b010 = request ch1, 3'b000 = none.
- `avg_ch0`, `avg_ch1`  out  12  latest averages per channel.
- `avg_valid`  out  1  one-cycle pulse when an average updates.
- `avg_ch`  out  1  channel of the current `avg_valid` pulse.
- `alarm`  out  2  bit n = channel n alarm.
- `busy`  out  1  high while a frame is in flight.

## Operation
- States: S_IDLE, S_START, S_WAIT, S_CAPTURE.
- S_IDLE: `enable` = 000. If `run` = 1, go to S_START.
- S_START: drive `enable` = code of `req_ch` for exactly 1 cycle, then go to S_WAIT.
- S_WAIT: count to FRAME_CYCLES-1, then go to S_CAPTURE.
- S_CAPTURE: latch `sample_12b`.
  - If `primed` = 0: discard the sample and set `primed`.
  - Otherwise: add the sample to the accumulator of `prev_ch` (the channel requested in the previous frame; AD7928 returns the prior conversion).
  - Then `prev_ch` ← `req_ch` and `req_ch` toggles.
  - Go to S_START if `run` = 1, else to S_IDLE and clear `primed`.
- Accumulator: width 12+AVG_LOG2, plus a counter per channel. When the counter wraps from 2^AVG_LOG2-1:
  - avg = sum >> AVG_LOG2 (truncate);
  - load `avg_chN`, pulse `avg_valid`, set `avg_ch` = N;
  - clear sum and count.
- Alarm per channel, evaluated on each avg update:
  - set if avg ≥ HI_CHx;
  - clear if avg < HI_CHx − HYST;
  - otherwise hold.
- Dropping `run` mid-frame does not abort the frame: the current frame completes and its capture is still accumulated. Partial accumulator contents are kept.
- `busy` = 1 in S_START, S_WAIT, S_CAPTURE.

## Timing
- Reset values: `enable` = 000, `avg_ch0` = `avg_ch1` = 0, `avg_valid` = 0, `avg_ch` = 0, `alarm` = 00, `busy` = 0, `req_ch` = 0, `prev_ch` = 0, `primed` = 0, accumulators = 0.
- Reset asserted mid-frame: all outputs go to reset values immediately. The first capture after reset is discarded.
- `run` rising edge to `enable` ≠ 000: 2 cycles (IDLE → START, then registered output).
- Frame period: FRAME_CYCLES + 2 cycles (START + WAIT + CAPTURE).
- First valid average: ch0 after 1 + 2·2^AVG_LOG2 − 1 frames.
- `avg_valid` asserts the cycle after S_CAPTURE. The two channels never pulse in the same cycle.
- `alarm` updates in the same cycle as `avg_valid`.

## Configuration
- `SENSOR_ALARM_EN`
  - Defined: alarm comparators and hysteresis logic are present.
  - Undefined: `alarm` is tied to 00, and HI_CH0, HI_CH1 and HYST are unused.

## Structure
- Package `sensor_mon_pkg` holds:
  - state encoding;
  - channel enable codes EN_CH0 = 3'b001, EN_CH1 = 3'b010, EN_NONE = 3'b000;
  - channel index constants.
- Sub-module `sensor_avg_acc` is instantiated once per channel. It contains the sum, the counter, the shift-divide and the optional alarm/hysteresis register.

## Test plan
- Reset, `run` = 1, SPI reader model returns 100 for ch0 conversions and 200 for ch1 conversions, AVG_LOG2 = 2 → first capture discarded; `avg_ch0` = 100 with `avg_ch` = 0 after 8 frames, `avg_ch1` = 200 on the next pulse.
- Ch0 samples 10, 11, 12, 13 with AVG_LOG2 = 2 → `avg_ch0` = 11 (46 >> 2, truncation).
- Ch0 averages 3000, then 2950, then 2930 with HI_CH0 = 3000, HYST = 64 → `alarm[0]` sets, holds at 2950, clears at 2930.
- `run` dropped mid S_WAIT → frame completes, capture accumulated, `enable` stays 000. Re-asserting `run` discards the first capture.
- `reset_n` pulsed low mid-frame → all outputs at reset values within the same cycle. The accumulator restart is confirmed by the next average being computed only from post-reset samples.
- `enable` is never non-zero for more than 1 consecutive cycle, and the spacing between non-zero codes is exactly FRAME_CYCLES + 2.
